// File: rtl/spike_det_pkg.sv
// -----------------------------------------------------------------------------
// spike_det_pkg
// Shared types and constants for the spike detector.
//   - det_state_e   : detection FSM states (calibration, idle, peak, refractory)
//   - SAMPLE_W      : width of the signed emphasised sample
//   - ABS_W         : width of the saturated |p| magnitude
//   - THR_W / CNT_W : threshold and spike-counter widths
//   - SPIKE_CNT_MAX : saturation value of the spike counter
//   - abs_sat()     : |p| saturated to ABS_W bits
// -----------------------------------------------------------------------------
package spike_det_pkg;

    localparam int SAMPLE_W = 12;
    localparam int ABS_W    = 11;
    localparam int THR_W    = 16;
    localparam int CNT_W    = 16;

    localparam logic [CNT_W-1:0] SPIKE_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_CALIB   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PEAK    = 2'd2,
        ST_REFRACT = 2'd3
    } det_state_e;

    // Magnitude of a signed sample. The most negative code has no positive
    // counterpart in ABS_W bits, so it clips to the largest magnitude.
    function automatic logic [ABS_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] mag;
        mag = s[SAMPLE_W-1] ? -s : s;
        return mag[SAMPLE_W-1] ? {ABS_W{1'b1}} : mag[ABS_W-1:0];
    endfunction

endpackage

// File: rtl/spike_detector_if.sv
// -----------------------------------------------------------------------------
// spike_detector_if
// Sample input and spike-event outputs of the spike detector.
//   p         : signed emphasised sample, one per clock (master -> slave)
//   spike     : one-cycle pulse per detected spike      (slave -> master)
//   peak      : excursion maximum, valid with spike      (slave -> master)
//   thr       : current adaptive threshold               (slave -> master)
//   thr_valid : first threshold window has completed     (slave -> master)
//   spike_cnt : saturating spike count                   (slave -> master)
// The upstream stage / readout side uses the master modport, the detector
// uses the slave modport.
// -----------------------------------------------------------------------------
interface spike_detector_if;
    import spike_det_pkg::*;

    logic signed [SAMPLE_W-1:0] p;
    logic                       spike;
    logic signed [SAMPLE_W-1:0] peak;
    logic [THR_W-1:0]           thr;
    logic                       thr_valid;
    logic [CNT_W-1:0]           spike_cnt;

    modport master (
        output p,
        input  spike, peak, thr, thr_valid, spike_cnt
    );

    modport slave (
        input  p,
        output spike, peak, thr, thr_valid, spike_cnt
    );

endinterface

// File: rtl/thr_estimator.sv
// -----------------------------------------------------------------------------
// thr_estimator
// Adaptive threshold: THR_MULT times the block mean of |p_r| over windows of
// 2^LOG2_WIN samples, floored at THR_MIN.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   p_r       : registered input sample
//   p_vld     : p_r holds a real sample (low only for the reset value)
//   thr       : registered threshold, updated at each window end
//   thr_valid : set when the first window completes, then stays set
//   thr_load  : combinational strobe, high in the cycle whose edge loads thr
// -----------------------------------------------------------------------------
module thr_estimator
    import spike_det_pkg::*;
#(
    parameter int LOG2_WIN = 8,
    parameter int THR_MULT = 8,
    parameter int THR_MIN  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] p_r,
    input  logic                       p_vld,
    output logic [THR_W-1:0]           thr,
    output logic                       thr_valid,
    output logic                       thr_load
);

    // Wide enough to sum 2^LOG2_WIN full-scale magnitudes without overflow.
    localparam int ACC_W = ABS_W + LOG2_WIN;

    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic [THR_W-1:0]    thr_q, thr_d;
    logic                thr_valid_q, thr_valid_d;
    logic [ABS_W-1:0]    p_abs;
    logic [ABS_W-1:0]    mean;
    logic [THR_W-1:0]    scaled;
    logic                win_end;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        thr_d       = thr_q;
        thr_valid_d = thr_valid_q;

        p_abs   = abs_sat(p_r);
        // The window total includes the sample registered at this edge.
        acc_sum = acc_q + ACC_W'(p_abs);
        mean    = ABS_W'(acc_sum >> LOG2_WIN);
        scaled  = THR_W'(mean) * THR_W'(THR_MULT);
        win_end = p_vld && (cnt_q == {LOG2_WIN{1'b1}});

        if (p_vld) begin
            // Counter wraps to zero at the window end by itself.
            cnt_d = cnt_q + LOG2_WIN'(1);
            acc_d = win_end ? '0 : acc_sum;
        end

        if (win_end) begin
            thr_d       = (scaled > THR_W'(THR_MIN)) ? scaled : THR_W'(THR_MIN);
            thr_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            thr_q       <= '0;
            thr_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            thr_q       <= thr_d;
            thr_valid_q <= thr_valid_d;
        end
    end

    assign thr       = thr_q;
    assign thr_valid = thr_valid_q;
    assign thr_load  = win_end;

endmodule

// File: rtl/spike_detector.sv
// -----------------------------------------------------------------------------
// spike_detector
// Detects above-threshold excursions of the emphasised sample stream, emits a
// one-cycle spike with the excursion peak when each excursion ends (or is
// forced at MAX_LEN samples), then ignores the input for REFRACT samples.
// Ports:
//   clk  : system clock, one sample per rising edge
//   rst  : asynchronous active-high reset
//   bus  : spike_detector_if.slave (p in; spike, peak, thr, thr_valid,
//          spike_cnt out)
// Build option:
//   SPIKE_DET_PEAK_EN : when defined, peak tracking is built in; otherwise
//                       peak is tied to zero.
// -----------------------------------------------------------------------------
module spike_detector
    import spike_det_pkg::*;
#(
    parameter int LOG2_WIN = 8,
    parameter int THR_MULT = 8,
    parameter int THR_MIN  = 16,
    parameter int REFRACT  = 32,
    parameter int MAX_LEN  = 64
) (
    input  logic             clk,
    input  logic             rst,
    spike_detector_if.slave  bus
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int REF_W = $clog2(REFRACT + 1);

    logic signed [SAMPLE_W-1:0] p_r_q, p_r_d;
    logic                       p_vld_q, p_vld_d;
    det_state_e                 state_q, state_d;
    logic [LEN_W-1:0]           len_q, len_d, len_inc;
    logic [REF_W-1:0]           rcnt_q, rcnt_d;
    logic                       spike_q, spike_d;
    logic [CNT_W-1:0]           spike_cnt_q, spike_cnt_d;
    logic [THR_W-1:0]           thr_cur;
    logic                       thr_valid_cur;
    logic                       thr_load;
    logic                       above;
    logic                       fire;

`ifdef SPIKE_DET_PEAK_EN
    logic signed [SAMPLE_W-1:0] peak_reg_q, peak_reg_d;
    logic signed [SAMPLE_W-1:0] peak_q, peak_d;
`endif

    thr_estimator #(
        .LOG2_WIN (LOG2_WIN),
        .THR_MULT (THR_MULT),
        .THR_MIN  (THR_MIN)
    ) u_thr_est (
        .clk       (clk),
        .rst       (rst),
        .p_r       (p_r_q),
        .p_vld     (p_vld_q),
        .thr       (thr_cur),
        .thr_valid (thr_valid_cur),
        .thr_load  (thr_load)
    );

    always_comb begin
        p_r_d       = bus.p;
        p_vld_d     = 1'b1;
        state_d     = state_q;
        len_d       = len_q;
        rcnt_d      = rcnt_q;
        spike_d     = 1'b0;
        spike_cnt_d = spike_cnt_q;
        fire        = 1'b0;

        // Strictly positive and strictly above the threshold currently held;
        // a threshold loaded at this edge only affects the next compare.
        above   = !p_r_q[SAMPLE_W-1] && (p_r_q != '0) &&
                  (THR_W'(p_r_q[ABS_W-1:0]) > thr_cur);
        len_inc = len_q + LEN_W'(1);

        case (state_q)
            ST_CALIB: begin
                if (thr_load) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (above) begin
                    state_d = ST_PEAK;
                    len_d   = LEN_W'(1);
                end
            end
            ST_PEAK: begin
                if (above) begin
                    len_d = len_inc;
                    if (len_inc == LEN_W'(MAX_LEN)) begin
                        fire = 1'b1;
                    end
                end else begin
                    fire = 1'b1;
                end
            end
            ST_REFRACT: begin
                // The input is ignored for the whole count, including the
                // sample present on the cycle that returns to IDLE.
                rcnt_d = rcnt_q + REF_W'(1);
                if (rcnt_q == REF_W'(REFRACT - 1)) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_CALIB;
            end
        endcase

        if (fire) begin
            spike_d = 1'b1;
            state_d = ST_REFRACT;
            len_d   = '0;
            rcnt_d  = '0;
            if (spike_cnt_q != SPIKE_CNT_MAX) begin
                spike_cnt_d = spike_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef SPIKE_DET_PEAK_EN
    always_comb begin
        peak_reg_d = peak_reg_q;
        peak_d     = peak_q;
        if ((state_q == ST_IDLE) && above) begin
            peak_reg_d = p_r_q;
        end else if ((state_q == ST_PEAK) && above && (p_r_q > peak_reg_q)) begin
            peak_reg_d = p_r_q;
        end
        // Taken from the updated running peak so a forced exit at MAX_LEN
        // includes the sample that triggered it.
        if (fire) begin
            peak_d = peak_reg_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_reg_q <= '0;
            peak_q     <= '0;
        end else begin
            peak_reg_q <= peak_reg_d;
            peak_q     <= peak_d;
        end
    end

    assign bus.peak = peak_q;
`else
    assign bus.peak = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r_q       <= '0;
            p_vld_q     <= 1'b0;
            state_q     <= ST_CALIB;
            len_q       <= '0;
            rcnt_q      <= '0;
            spike_q     <= 1'b0;
            spike_cnt_q <= '0;
        end else begin
            p_r_q       <= p_r_d;
            p_vld_q     <= p_vld_d;
            state_q     <= state_d;
            len_q       <= len_d;
            rcnt_q      <= rcnt_d;
            spike_q     <= spike_d;
            spike_cnt_q <= spike_cnt_d;
        end
    end

    assign bus.spike     = spike_q;
    assign bus.thr       = thr_cur;
    assign bus.thr_valid = thr_valid_cur;
    assign bus.spike_cnt = spike_cnt_q;

endmodule

// File: tb/tb_spike_detector.sv
// -----------------------------------------------------------------------------
// tb_spike_detector
// Directed and randomized checks of spike_detector against a sample-level
// reference model of the detection rules.
// Build option: SPIKE_DET_PEAK_EN selects whether peak is expected to track.
// -----------------------------------------------------------------------------
module tb_spike_detector;
    import spike_det_pkg::*;

    localparam int LOG2_WIN    = 4;
    localparam int THR_MULT    = 8;
    localparam int THR_MIN     = 16;
    localparam int REFRACT_LEN = 8;
    localparam int MAX_LEN     = 16;

`ifdef SPIKE_DET_PEAK_EN
    localparam int PEAK_EXP = 100;
`else
    localparam int PEAK_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    spike_detector_if bus ();

    spike_detector #(
        .LOG2_WIN (LOG2_WIN),
        .THR_MULT (THR_MULT),
        .THR_MIN  (THR_MIN),
        .REFRACT  (REFRACT_LEN),
        .MAX_LEN  (MAX_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: sample-by-sample application of the detection rules.
    int m_pr;
    bit m_pr_vld;
    int m_sum, m_n, m_thr;
    bit m_thr_valid;
    bit m_calib, m_in_exc;
    int m_run_peak, m_len, m_refr_left;
    bit m_spike;
    int m_peak, m_cnt;

    function automatic void model_reset();
        m_pr = 0; m_pr_vld = 0;
        m_sum = 0; m_n = 0; m_thr = 0; m_thr_valid = 0;
        m_calib = 1; m_in_exc = 0;
        m_run_peak = 0; m_len = 0; m_refr_left = 0;
        m_spike = 0; m_peak = 0; m_cnt = 0;
    endfunction

    // One clock edge: the previously registered sample is evaluated, the new
    // one is registered.
    function automatic void model_step(input int smp);
        bit above, win_end, fire;
        above   = (m_pr > 0) && (m_pr > m_thr);
        win_end = 0;
        fire    = 0;
        if (m_pr_vld) begin
            m_sum += (m_pr < 0) ? ((-m_pr > 2047) ? 2047 : -m_pr) : m_pr;
            m_n++;
            if (m_n == (1 << LOG2_WIN)) begin
                m_thr = (m_sum / (1 << LOG2_WIN)) * THR_MULT;
                if (m_thr < THR_MIN) m_thr = THR_MIN;
                m_thr_valid = 1; m_sum = 0; m_n = 0; win_end = 1;
            end
        end
        if (m_calib) begin
            if (win_end) m_calib = 0;
        end else if (m_refr_left > 0) begin
            m_refr_left--;
        end else if (m_in_exc) begin
            if (above) begin
                if (m_pr > m_run_peak) m_run_peak = m_pr;
                m_len++;
                if (m_len == MAX_LEN) fire = 1;
            end else begin
                fire = 1;
            end
        end else if (above) begin
            m_in_exc = 1; m_run_peak = m_pr; m_len = 1;
        end
        m_spike = fire;
        if (fire) begin
            m_peak = m_run_peak;
            m_in_exc = 0;
            m_refr_left = REFRACT_LEN;
            if (m_cnt < 65535) m_cnt++;
        end
        m_pr = smp; m_pr_vld = 1;
    endfunction

    function automatic int exp_peak();
`ifdef SPIKE_DET_PEAK_EN
        return m_peak;
`else
        return 0;
`endif
    endfunction

    task automatic drive(input int smp);
        bus.p = 12'(smp);
        @(posedge clk);
        model_step(smp);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.p = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.p = 12'sd4;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.spike !== 1'b0 || bus.peak !== 12'd0 || bus.thr !== 16'd0 ||
                bus.thr_valid !== 1'b0 || bus.spike_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_outputs: spike=%b peak=%0d thr=%0d thr_valid=%b cnt=%0d, required all 0",
                         bus.spike, bus.peak, bus.thr, bus.thr_valid, bus.spike_cnt);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_calib();
        for (int i = 0; i < 16; i++) begin
            drive(4);
            checks++;
            if (bus.spike !== m_spike || bus.thr_valid !== m_thr_valid) begin
                errors++;
                $display("FAIL calib_cycle%0d: spike=%b thr_valid=%b, required %b %b",
                         i, bus.spike, bus.thr_valid, m_spike, m_thr_valid);
            end
        end
        checks++;
        if (bus.thr_valid !== 1'b0) begin
            errors++;
            $display("FAIL calib_not_yet_valid: thr_valid=%b, required 0", bus.thr_valid);
        end
    endtask

    task automatic test_spike_refract();
        int seq [22] = '{40, 100, 60, 4, 4, 4, 4, 40, 100, 60, 4,
                         4, 4, 4, 40, 100, 60, 4, 4, 4, 4, 4};
        int nspk = 0;
        for (int i = 0; i < 22; i++) begin
            drive(seq[i]);
            if (i == 0) begin
                checks++;
                if (bus.thr !== 16'd32 || bus.thr_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL first_thr: thr=%0d thr_valid=%b, required 32 1", bus.thr, bus.thr_valid);
                end
            end
            checks++;
            if (bus.spike !== m_spike || bus.spike_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL pulse_cycle%0d: spike=%b cnt=%0d, required %b %0d",
                         i, bus.spike, bus.spike_cnt, m_spike, m_cnt);
            end
            if (bus.spike === 1'b1) nspk++;
            if (i == 4 || i == 17) begin
                checks++;
                if (bus.spike !== 1'b1 || bus.peak !== 12'(PEAK_EXP) ||
                    bus.spike_cnt !== ((i == 4) ? 16'd1 : 16'd2)) begin
                    errors++;
                    $display("FAIL spike_at_%0d: spike=%b peak=%0d cnt=%0d, required 1 %0d %0d",
                             i, bus.spike, bus.peak, bus.spike_cnt, PEAK_EXP, (i == 4) ? 1 : 2);
                end
            end
        end
        checks++;
        if (nspk != 2) begin
            errors++;
            $display("FAIL refract_spike_count: got %0d spikes, required 2", nspk);
        end
    endtask

    task automatic test_floor();
        apply_reset();
        for (int i = 0; i < 17; i++) drive(1);
        checks++;
        if (bus.thr !== 16'd16 || bus.thr_valid !== 1'b1 || bus.spike_cnt !== 16'd0) begin
            errors++;
            $display("FAIL thr_floor: thr=%0d thr_valid=%b cnt=%0d, required 16 1 0",
                     bus.thr, bus.thr_valid, bus.spike_cnt);
        end
    endtask

    task automatic test_forced();
        int nspk = 0;
        apply_reset();
        for (int i = 0; i < 16; i++) drive(4);
        for (int i = 0; i < 32; i++) begin
            drive((i < 20) ? 100 : 4);
            checks++;
            if (bus.spike !== m_spike || bus.peak !== 12'(exp_peak())) begin
                errors++;
                $display("FAIL forced_cycle%0d: spike=%b peak=%0d, required %b %0d",
                         i, bus.spike, bus.peak, m_spike, exp_peak());
            end
            if (bus.spike === 1'b1) nspk++;
            if (i == 16) begin
                checks++;
                if (bus.spike !== 1'b1 || bus.peak !== 12'(PEAK_EXP) || bus.spike_cnt !== 16'd1) begin
                    errors++;
                    $display("FAIL forced_spike: spike=%b peak=%0d cnt=%0d, required 1 %0d 1",
                             bus.spike, bus.peak, bus.spike_cnt, PEAK_EXP);
                end
            end
        end
        checks++;
        if (nspk != 1) begin
            errors++;
            $display("FAIL forced_spike_count: got %0d spikes, required 1", nspk);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 40; i++) drive(4);
        drive(40);
        drive(100);
        checks++;
        if (bus.spike_cnt !== 16'(m_cnt) || bus.thr_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d thr_valid=%b, required %0d 1", bus.spike_cnt, bus.thr_valid, m_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dut.state_q !== ST_CALIB || bus.thr_valid !== 1'b0 ||
            bus.spike_cnt !== 16'd0 || bus.spike !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: state=%0d thr_valid=%b cnt=%0d spike=%b, required CALIB 0 0 0",
                     dut.state_q, bus.thr_valid, bus.spike_cnt, bus.spike);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 24; i++) begin
            drive(4);
            checks++;
            if (bus.spike !== 1'b0 || bus.spike_cnt !== 16'd0) begin
                errors++;
                $display("FAIL post_reset_cycle%0d: spike=%b cnt=%0d, required 0 0",
                         i, bus.spike, bus.spike_cnt);
            end
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            drive(-2048);
            checks++;
            if (bus.spike !== 1'b0) begin
                errors++;
                $display("FAIL sat_spike%0d: spike=%b, required 0", i, bus.spike);
            end
        end
        checks++;
        if (bus.thr !== 16'd16376 || bus.thr_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_thr: thr=%0d thr_valid=%b, required 16376 1", bus.thr, bus.thr_valid);
        end
    endtask

    task automatic test_random();
        int pulse_left = 0;
        int amp = 0;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            int smp;
            if (pulse_left == 0 && $urandom_range(0, 19) == 0) begin
                pulse_left = int'($urandom_range(1, 20));
                amp = int'($urandom_range(20, 2047));
                if ($urandom_range(0, 3) == 0) amp = -amp;
            end
            if (pulse_left > 0) begin
                smp = amp - int'($urandom_range(0, 10));
                pulse_left--;
            end else begin
                smp = int'($urandom_range(0, 16)) - 8;
            end
            if (smp < -2048) smp = -2048;
            drive(smp);
            checks++;
            if (bus.spike !== m_spike || bus.peak !== 12'(exp_peak()) ||
                bus.thr !== 16'(m_thr) || bus.thr_valid !== m_thr_valid ||
                bus.spike_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL random_cycle%0d: spike=%b peak=%0d thr=%0d valid=%b cnt=%0d, required %b %0d %0d %b %0d",
                         i, bus.spike, bus.peak, bus.thr, bus.thr_valid, bus.spike_cnt,
                         m_spike, exp_peak(), m_thr, m_thr_valid, m_cnt);
            end
        end
    endtask

    initial begin
        bus.p = '0;
        model_reset();
        test_reset();
        test_calib();
        test_spike_refract();
        test_floor();
        test_forced();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
